// File: rtl/pipe_mux_stage.sv
// Registered N:1 select stage with valid/ready handshake, 2-entry skid buffer and sync flush.
// Define PIPE_MUX_STALL_CNT_EN to add the saturating 16-bit stall_cnt output.
module pipe_mux_stage #(
    parameter int unsigned      WIDTH   = 9,
    parameter int unsigned      NUM_SRC = 2,
    parameter logic [WIDTH-1:0] BUBBLE  = '0,
    localparam int unsigned     SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     flush
`ifdef PIPE_MUX_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] captured;
    logic             accept;
    logic             pop;

    // Ready depends on registered state only, so no comb path from out_ready to in_ready.
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign out_data  = head_q;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Out-of-range selects fall through to BUBBLE.
    always_comb begin
        captured = BUBBLE;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                captured = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q <= StEmpty;
            head_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_q <= StOne;
                        head_q  <= captured;
                    end
                end
                StOne: begin
                    if (accept && !pop) begin
                        state_q <= StFull;
                        skid_q  <= captured;
                    end else if (accept && pop) begin
                        head_q <= captured;
                    end else if (pop) begin
                        state_q <= StEmpty;
                        head_q  <= BUBBLE;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_q <= StOne;
                        head_q  <= skid_q;
                        skid_q  <= BUBBLE;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                    head_q  <= BUBBLE;
                    skid_q  <= BUBBLE;
                end
            endcase
        end
    end

`ifdef PIPE_MUX_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            stall_cnt_q <= 16'h0000;
        end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_mux_stage.sv
// Randomised + directed bench for pipe_mux_stage against a queue-based reference model.
// Exercises stall_cnt as well when PIPE_MUX_STALL_CNT_EN is defined.
module tb_pipe_mux_stage;

    localparam int W    = 9;
    localparam int NSRC = 3;
    localparam int SELW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NSRC*W-1:0] in_data;
    logic [SELW-1:0]   in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic              flush;
`ifdef PIPE_MUX_STALL_CNT_EN
    logic [15:0]       stall_cnt;
    int unsigned       stall_model;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] mq[$];

    always #5 clk = ~clk;

    pipe_mux_stage #(
        .WIDTH   (W),
        .NUM_SRC (NSRC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush)
`ifdef PIPE_MUX_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [NSRC*W-1:0] data,
                                          input logic [SELW-1:0] sel);
        logic [NSRC*W-1:0] sh;
        if (int'(sel) >= NSRC) return '0;
        sh = data >> (int'(sel) * W);
        return sh[W-1:0];
    endfunction

    task automatic check_model();
        logic [W-1:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : '0;
        check_eq("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check_eq("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        check_eq("out_data", 32'(out_data), 32'(exp_data));
`ifdef PIPE_MUX_STALL_CNT_EN
        check_eq("stall_cnt", 32'(stall_cnt), 32'(stall_model));
`endif
    endtask

    // One clock: update the model from the inputs seen at the edge, then check.
    task automatic cycle();
        bit acc;
        bit stalled;
        @(posedge clk);
        acc     = in_valid && (mq.size() < 2);
        stalled = (mq.size() > 0) && !out_ready;
        if (!rst_n || flush) begin
            mq.delete();
`ifdef PIPE_MUX_STALL_CNT_EN
            stall_model = 0;
`endif
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (acc) mq.push_back(pick(in_data, in_sel));
`ifdef PIPE_MUX_STALL_CNT_EN
            if (stalled && stall_model < 65535) stall_model++;
`endif
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic [63:0] r;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_sel    = '0;
`ifdef PIPE_MUX_STALL_CNT_EN
        stall_model = 0;
`endif
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        check_eq("reset_valid", 32'(out_valid), 32'd0);
        check_eq("reset_data", 32'(out_data), 32'h000);
        check_eq("reset_ready", 32'(in_ready), 32'd1);

        // Single beat
        in_data   = {9'h055, 9'h1A5, 9'h0F3};
        in_sel    = 2'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cycle();
        check_eq("single_data", 32'(out_data), 32'h1A5);
        check_eq("single_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        cycle();
        check_eq("single_drain_valid", 32'(out_valid), 32'd0);
        check_eq("single_drain_data", 32'(out_data), 32'h000);

        // Backpressure: A, B fill, C held off until space opens
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = {9'h000, 9'h000, 9'h011};
        cycle();
        in_data   = {9'h000, 9'h000, 9'h022};
        cycle();
        check_eq("bp_full_ready", 32'(in_ready), 32'd0);
        in_data   = {9'h000, 9'h000, 9'h033};
        cycle();
        cycle();
        check_eq("bp_hold_a", 32'(out_data), 32'h011);
        out_ready = 1'b1;
        cycle();
        check_eq("bp_out_b", 32'(out_data), 32'h022);
        check_eq("bp_ready_back", 32'(in_ready), 32'd1);
        cycle();
        check_eq("bp_out_c", 32'(out_data), 32'h033);
        in_valid = 1'b0;
        cycle();
        check_eq("bp_empty", 32'(out_valid), 32'd0);

        // Out-of-range select captures BUBBLE
        in_data   = {9'h1FF, 9'h1FF, 9'h1FF};
        in_sel    = 2'd3;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        cycle();
        check_eq("oor_valid", 32'(out_valid), 32'd1);
        check_eq("oor_data", 32'(out_data), 32'h000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();

        // Flush while FULL with an incoming beat
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = {9'h0AA, 9'h000, 9'h000};
        cycle();
        in_data   = {9'h0BB, 9'h000, 9'h000};
        cycle();
        check_eq("fl_full", 32'(in_ready), 32'd0);
        flush   = 1'b1;
        in_data = {9'h0CC, 9'h000, 9'h000};
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_valid", 32'(out_valid), 32'd0);
        check_eq("fl_data", 32'(out_data), 32'h000);
        check_eq("fl_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        cycle();
        cycle();
        check_eq("fl_nothing", 32'(out_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r         = {$urandom(), $urandom()};
            rst_n     = ($urandom_range(0, 99) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_sel    = SELW'($urandom_range(0, 3));
            in_data   = r[NSRC*W-1:0];
            cycle();
        end
        rst_n = 1'b1;
        flush = 1'b0;

`ifdef PIPE_MUX_STALL_CNT_EN
        rst_n = 1'b0;
        cycle();
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        repeat (5) cycle();
        check_eq("stall_five", 32'(stall_cnt), 32'd5);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check_eq("stall_flush", 32'(stall_cnt), 32'd0);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (70000) cycle();
        check_eq("stall_sat", 32'(stall_cnt), 32'h0000FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_mux_stage.md
Name: pipe_mux_stage

Overview:
- Parametrised registered N:1 selector stage with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
- Generalises the fixed 9-bit combinational 2:1 control mux used for hazard bubbling into a pipeline-stage primitive.
- Sits between pipeline stages, e.g. ID->EX control and forwarded operands. It selects one of NUM_SRC sources, registers it, and absorbs one cycle of downstream stall without a combinational ready path.

Parameters:
WIDTH, 9, data width per source and of the output.
NUM_SRC, 2, number of selectable sources (>=2).
BUBBLE, 0 (WIDTH bits), value driven on out_data when empty or flushed, and captured when in_sel is out of range.
SEL_W is a derived localparam equal to clog2(NUM_SRC); it is not overridable.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset.
in_data  input  NUM_SRC*WIDTH  concatenated sources; source k occupies bits [k*WIDTH +: WIDTH].
in_sel  input  SEL_W  source select, sampled on accept.
in_valid  input  1  upstream beat valid.
in_ready  output  1  stage can accept a beat this cycle.
out_data  output  WIDTH  head entry data.
out_valid  output  1  head entry valid.
out_ready  input  1  downstream accepts head.
flush  input  1  synchronous kill of all held and incoming beats.

Behaviour:
- Reset (rst_n=0 at a clk edge): state EMPTY, out_valid=0, out_data=BUBBLE, in_ready=1. Skid register cleared to BUBBLE.
- Storage: head register (drives out_data/out_valid) and skid register. in_ready is a function of state only (no in_valid/out_ready path): in_ready=1 in EMPTY and ONE, 0 in FULL.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Captured value = in_data[in_sel*WIDTH +: WIDTH] if in_sel < NUM_SRC, else BUBBLE.
- Latency: beat accepted at edge N appears on out_data/out_valid after edge N (1 cycle) when the stage was EMPTY, or when ONE with a simultaneous pop.
- State transitions, flush=0:
  - EMPTY: accept -> ONE (head<=captured).
  - ONE: accept & !pop -> FULL (skid<=captured). accept & pop -> ONE (head<=captured). !accept & pop -> EMPTY (out_data<=BUBBLE). Otherwise hold.
  - FULL: pop -> ONE (head<=skid, skid<=BUBBLE). Otherwise hold. Input is never accepted in FULL.
- Flush=1 (priority over everything except reset): next state EMPTY, out_valid=0, out_data=BUBBLE, skid=BUBBLE. A beat handshaken in the same cycle is discarded. A pop in the same cycle still counts as consumed by downstream. in_ready is 1 the cycle after.
- Ordering: beats leave in acceptance order. No duplication, no loss except by flush.
- out_data is held stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation overrides flush and handshakes and returns to the reset values above.

Optional Feature:
Macro PIPE_MUX_STALL_CNT_EN.
- Defined: adds output port stall_cnt, output, 16 bits.
  - Increments each cycle out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by reset or flush.
  - Counts the flush cycle itself as not stalled.
- Undefined: the port and the counter logic do not exist. Handshake behaviour is identical in both builds.

Test Plan:
- Reset, then idle with WIDTH=9, NUM_SRC=2 -> out_valid=0, out_data=9'h000, in_ready=1.
- Single beat: sources {9'h1A5, 9'h0F3}, in_sel=1, in_valid=1, out_ready=1 -> after 1 edge out_data=9'h1A5, out_valid=1. Next cycle with in_valid=0 -> out_valid=0, out_data=BUBBLE.
- Backpressure: out_ready=0, push A=9'h011 then B=9'h022 -> state FULL, in_ready=0, third beat C not accepted. Release out_ready -> outputs A, B in order, then C is accepted once in_ready=1.
- Out-of-range select: NUM_SRC=3, SEL_W=2, in_sel=3 -> captured value BUBBLE, out_valid=1.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0, out_data=BUBBLE, in_ready=1. Neither held beat nor the incoming beat ever appears.
- With PIPE_MUX_STALL_CNT_EN: hold out_ready=0 for 5 cycles with a valid head -> stall_cnt=5. Flush -> stall_cnt=0. Force 70000 stall cycles -> stall_cnt=16'hFFFF.
